// File: rtl/sram_pkt_ctrl.sv
// Packet-buffer controller: writes whole RX packets into a circular SRAM region and streams
// committed packets to the reader. Define SRAM_PKT_STATS_EN to add pkt_cnt/drop_cnt outputs.
module sram_pkt_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DESC_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              pkt_avail,
    output logic [ADDR_W:0]   pkt_len,
    input  logic              rd_req,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_eop,
    output logic              mem_write,
    output logic [31:0]       mem_wr_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read,
    output logic [31:0]       mem_rd_addr,
    input  logic [DATA_W-1:0] mem_data_out
`ifdef SRAM_PKT_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned NDESC = 2 ** DESC_W;
    localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {WrIdle, WrPkt, WrDrop} wr_state_e;
    typedef enum logic {RdIdle, RdXfer} rd_state_e;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_start_q, wr_start_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   wr_len_q, wr_len_d, used_q, used_d, rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] desc_start_q [NDESC];
    logic [ADDR_W:0]   desc_len_q [NDESC];
    logic [DESC_W:0]   desc_wr_q, desc_rd_q;

    logic              fifo_full, fifo_empty, can_start, do_start, push, pop;
    logic              drop_abort, drop_reject;
    logic [ADDR_W-1:0] start_addr, wr_addr, push_start, head_start;
    logic [ADDR_W:0]   new_len, push_len, head_len;
    logic [ADDR_W+1:0] need_words;

    assign fifo_empty = (desc_wr_q == desc_rd_q);
    assign fifo_full  = (desc_wr_q[DESC_W] != desc_rd_q[DESC_W]) &&
                        (desc_wr_q[DESC_W-1:0] == desc_rd_q[DESC_W-1:0]);
    assign head_start = desc_start_q[desc_rd_q[DESC_W-1:0]];
    assign head_len   = desc_len_q[desc_rd_q[DESC_W-1:0]];
    assign can_start  = !fifo_full && (used_q != DEPTH);
    assign new_len    = wr_len_q + LEN_ONE;
    // Committed words plus the in-progress packet including the current word.
    assign need_words = {1'b0, used_q} + {1'b0, new_len};

    assign pkt_avail   = !fifo_empty;
    assign pkt_len     = fifo_empty ? '0 : head_len;
    assign mem_wr_addr = {{(32 - ADDR_W){1'b0}}, wr_addr};
    assign mem_data_in = mem_write ? in_data : '0;
    assign mem_rd_addr = mem_read ? {{(32 - ADDR_W){1'b0}}, rd_ptr_q} : 32'd0;

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_start_d  = wr_start_q;
        wr_len_d    = wr_len_q;
        wr_addr     = wr_ptr_q;
        mem_write   = 1'b0;
        push        = 1'b0;
        push_start  = wr_start_q;
        push_len    = new_len;
        do_start    = 1'b0;
        start_addr  = wr_ptr_q;
        drop_abort  = 1'b0;
        drop_reject = 1'b0;
        if (in_valid) begin
            unique case (wr_state_q)
                WrPkt: begin
                    if (in_sop) begin
                        // Restart: the partial packet is abandoned and its space reused.
                        drop_abort = 1'b1;
                        do_start   = 1'b1;
                        start_addr = wr_start_q;
                    end else if (need_words > {1'b0, DEPTH}) begin
                        drop_abort = 1'b1;
                        wr_ptr_d   = wr_start_q;
                        wr_state_d = in_eop ? WrIdle : WrDrop;
                    end else begin
                        mem_write = 1'b1;
                        wr_ptr_d  = wr_ptr_q + PTR_ONE;
                        wr_len_d  = new_len;
                        if (in_eop) begin
                            push       = 1'b1;
                            wr_state_d = WrIdle;
                        end
                    end
                end
                WrDrop: begin
                    if (in_sop) begin
                        do_start = 1'b1;
                    end else if (in_eop) begin
                        wr_state_d = WrIdle;
                    end
                end
                default: do_start = in_sop;
            endcase
        end
        if (do_start) begin
            wr_addr = start_addr;
            if (can_start) begin
                mem_write  = 1'b1;
                wr_start_d = start_addr;
                wr_ptr_d   = start_addr + PTR_ONE;
                wr_len_d   = LEN_ONE;
                push_start = start_addr;
                push_len   = LEN_ONE;
                if (in_eop) begin
                    push       = 1'b1;
                    wr_state_d = WrIdle;
                end else begin
                    wr_state_d = WrPkt;
                end
            end else begin
                drop_reject = 1'b1;
                wr_ptr_d    = start_addr;
                wr_state_d  = in_eop ? WrIdle : WrDrop;
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_cnt_d   = rd_cnt_q;
        pop        = 1'b0;
        mem_read   = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_eop     = 1'b0;
        unique case (rd_state_q)
            RdXfer: begin
                mem_read = 1'b1;
                rd_valid = 1'b1;
                rd_data  = mem_data_out;
                rd_eop   = (rd_cnt_q == LEN_ONE);
                if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    rd_cnt_d = rd_cnt_q - LEN_ONE;
                    if (rd_cnt_q == LEN_ONE) begin
                        pop        = 1'b1;
                        rd_state_d = RdIdle;
                    end
                end
            end
            default: begin
                if (rd_req && !fifo_empty) begin
                    rd_ptr_d   = head_start;
                    rd_cnt_d   = head_len;
                    rd_state_d = RdXfer;
                end
            end
        endcase
    end

    assign used_d = used_q + (push ? push_len : '0) - (pop ? head_len : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            wr_ptr_q   <= '0;
            wr_start_q <= '0;
            wr_len_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            used_q     <= '0;
            desc_wr_q  <= '0;
            desc_rd_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_start_q <= wr_start_d;
            wr_len_q   <= wr_len_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            used_q     <= used_d;
            if (push) desc_wr_q <= desc_wr_q + 1'b1;
            if (pop) desc_rd_q <= desc_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            desc_start_q[desc_wr_q[DESC_W-1:0]] <= push_start;
            desc_len_q[desc_wr_q[DESC_W-1:0]]   <= push_len;
        end
    end

`ifdef SRAM_PKT_STATS_EN
    logic [16:0] pkt_sum, drop_sum;
    logic [15:0] pkt_cnt_q, drop_cnt_q;

    assign pkt_sum  = {1'b0, pkt_cnt_q} + {16'd0, push};
    assign drop_sum = {1'b0, drop_cnt_q} + {16'd0, drop_abort} + {16'd0, drop_reject};
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_abort | drop_reject;
`endif

endmodule

// File: tb/tb_sram_pkt_ctrl.sv
// Self-checking bench for sram_pkt_ctrl: table vectors, directed corner sequences and a
// randomized phase scored against a packet-level reference model.
module tb_sram_pkt_ctrl;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_sop, in_eop, rd_req, rd_ready;
    logic [63:0] in_data;
    logic        pkt_avail, rd_valid, rd_eop, mem_write, mem_read;
    logic [11:0] pkt_len;
    logic [63:0] rd_data, mem_data_in, mem_data_out;
    logic [31:0] mem_wr_addr, mem_rd_addr;
`ifdef SRAM_PKT_STATS_EN
    logic [15:0] pkt_cnt, drop_cnt;
`endif

    sram_pkt_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .pkt_avail    (pkt_avail),
        .pkt_len      (pkt_len),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_eop       (rd_eop),
        .mem_write    (mem_write),
        .mem_wr_addr  (mem_wr_addr),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out)
`ifdef SRAM_PKT_STATS_EN
        ,
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // SRAM: synchronous write, combinational read.
    logic [63:0] sram [2048];
    always @(posedge clk) if (mem_write) sram[mem_wr_addr[10:0]] <= mem_data_in;
    assign mem_data_out = sram[mem_rd_addr[10:0]];

    int checks = 0;
    int errors = 0;

    // Packet-level reference model.
    logic [63:0] mq_data[$];
    int          mq_len[$];
    logic [63:0] m_cur[$];
    int          m_used;
    int          m_state;  // 0 idle, 1 in packet, 2 dropping

    typedef struct {
        logic        v;
        logic        sop;
        logic        eop;
        logic [63:0] d;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic        exp_avail;
        logic [11:0] exp_len;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_commit();
        mq_len.push_back(m_cur.size());
        foreach (m_cur[i]) mq_data.push_back(m_cur[i]);
        m_used += m_cur.size();
        m_cur.delete();
        m_state = 0;
    endfunction

    function automatic void model_word(input logic sop, input logic eop, input logic [63:0] d);
        if (sop) begin
            m_cur.delete();
            if (mq_len.size() == 16 || m_used == 2048) begin
                m_state = eop ? 0 : 2;
            end else begin
                m_cur.push_back(d);
                m_state = 1;
                if (eop) model_commit();
            end
        end else if (m_state == 1) begin
            if (m_used + m_cur.size() + 1 > 2048) begin
                m_cur.delete();
                m_state = eop ? 0 : 2;
            end else begin
                m_cur.push_back(d);
                if (eop) model_commit();
            end
        end else if (m_state == 2 && eop) begin
            m_state = 0;
        end
    endfunction

    task automatic reset_dut();
        reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        rd_req = 1'b0; rd_ready = 1'b0; in_data = '0;
        tick();
        tick();
        reset = 1'b0;
        mq_data.delete(); mq_len.delete(); m_cur.delete();
        m_used = 0; m_state = 0;
    endtask

    task automatic send_word(input logic sop, input logic eop, input logic [63:0] d);
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
        model_word(sop, eop, d);
        tick();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            send_word(i == 0, i == len - 1, {$urandom, $urandom});
            if (gaps && $urandom_range(0, 3) == 0) tick();
        end
    endtask

    // Sends a packet and checks each word is written at consecutive wrapped addresses.
    task automatic send_pkt_at(input int len, input int addr);
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1; in_sop = (i == 0); in_eop = (i == len - 1);
            in_data = {$urandom, $urandom};
            model_word(in_sop, in_eop, in_data);
            #1;
            chk("wr_en_at", 64'(mem_write), 64'd1);
            chk("wr_addr_at", 64'(mem_wr_addr), 64'((addr + i) % 2048));
            tick();
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    // mode 0: random ready, 1: always ready, 2: ready low 3 cycles at word 2
    task automatic read_pkt(input int mode);
        int n, idx, cyc, stall;
        chk("pkt_avail", 64'(pkt_avail), 64'd1);
        chk("pkt_len", 64'(pkt_len), 64'(mq_len[0]));
        n = mq_len.pop_front();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        idx = 0; cyc = 0; stall = 3;
        while (idx < n && cyc < 20 * n + 50) begin
            if (mode == 1) rd_ready = 1'b1;
            else if (mode == 2) rd_ready = !(idx == 2 && stall > 0);
            else rd_ready = ($urandom_range(0, 3) != 0);
            if (!rd_ready) stall--;
            chk("rd_valid", 64'(rd_valid), 64'd1);
            chk("rd_data", rd_data, mq_data[idx]);
            chk("rd_eop", 64'(rd_eop), 64'(idx == n - 1));
            if (rd_ready) idx++;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_words", 64'(idx), 64'(n));
        chk("rd_valid_end", 64'(rd_valid), 64'd0);
        for (int i = 0; i < n; i++) void'(mq_data.pop_front());
        m_used -= n;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // v sop eop data wr addr avail len
        tbl[0] = '{1'b1, 1'b0, 1'b0, 64'h11,  1'b0, 32'd0, 1'b0, 12'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 64'hA5,  1'b1, 32'd0, 1'b1, 12'd1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 64'h1,   1'b1, 32'd1, 1'b1, 12'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 64'h0,   1'b0, 32'd0, 1'b1, 12'd1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 64'h2,   1'b1, 32'd2, 1'b1, 12'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 64'h3,   1'b1, 32'd1, 1'b1, 12'd1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 64'h4,   1'b1, 32'd2, 1'b1, 12'd1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 64'h5,   1'b1, 32'd3, 1'b1, 12'd1};

        reset_dut();
        chk("rst_pkt_avail", 64'(pkt_avail), 64'd0);
        chk("rst_pkt_len", 64'(pkt_len), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);

        // Table: stray word, 1-word packet, then sop mid-packet restart.
        for (int i = 0; i < 8; i++) begin
            in_valid = tbl[i].v; in_sop = tbl[i].sop; in_eop = tbl[i].eop; in_data = tbl[i].d;
            if (tbl[i].v) model_word(tbl[i].sop, tbl[i].eop, tbl[i].d);
            #1;
            chk($sformatf("tbl%0d_wr", i), 64'(mem_write), 64'(tbl[i].exp_wr));
            if (tbl[i].exp_wr) begin
                chk($sformatf("tbl%0d_addr", i), 64'(mem_wr_addr), 64'(tbl[i].exp_addr));
                chk($sformatf("tbl%0d_wdata", i), mem_data_in, tbl[i].d);
            end
            tick();
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            chk($sformatf("tbl%0d_avail", i), 64'(pkt_avail), 64'(tbl[i].exp_avail));
            if (tbl[i].exp_avail)
                chk($sformatf("tbl%0d_len", i), 64'(pkt_len), 64'(tbl[i].exp_len));
        end
        read_pkt(0);
        read_pkt(0);
        chk("tbl_drained", 64'(pkt_avail), 64'd0);

        // 4-word packet with a 3-cycle stall mid-stream.
        send_pkt(4, 1'b0);
        read_pkt(2);

        // rd_req with nothing committed is ignored.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("idle_req_valid", 64'(rd_valid), 64'd0);

        // Reset in the middle of a read.
        send_pkt(3, 1'b0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        rd_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("midrd_rst_avail", 64'(pkt_avail), 64'd0);
        chk("midrd_rst_valid", 64'(rd_valid), 64'd0);
        chk("midrd_rst_read", 64'(mem_read), 64'd0);
        reset_dut();

        // Fill to 2040 words, overflow drop, descriptor-full drop, then wrap.
        for (int p = 0; p < 15; p++) send_pkt(136, 1'b0);
        send_pkt(16, 1'b0);
`ifdef SRAM_PKT_STATS_EN
        chk("drop_cnt_overflow", 64'(drop_cnt), 64'd1);
        chk("pkt_cnt_fill", 64'(pkt_cnt), 64'd15);
`endif
        send_pkt_at(6, 2040);
        in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_data = 64'hDEAD;
        model_word(1'b1, 1'b1, 64'hDEAD);
        #1;
        chk("desc_full_nowrite", 64'(mem_write), 64'd0);
        tick();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        read_pkt(1);
        send_pkt_at(4, 2046);
        while (mq_len.size() > 0) read_pkt(1);
        chk("fill_drained", 64'(pkt_avail), 64'd0);

        // Randomized phase.
        reset_dut();
        for (int it = 0; it < 120; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 9) begin
                send_pkt($urandom_range(1, 48), 1'b1);
            end else if (r < 11) begin
                send_pkt($urandom_range(200, 600), 1'b0);
            end else if (r == 11) begin
                for (int k = 0; k < 3; k++) send_word(k == 0, 1'b0, {$urandom, $urandom});
                send_pkt($urandom_range(1, 10), 1'b1);
            end else if (r == 12) begin
                send_word(1'b0, $urandom_range(0, 1) == 1, {$urandom, $urandom});
            end else if (mq_len.size() > 0) begin
                read_pkt(0);
            end else begin
                rd_req = 1'b1;
                tick();
                rd_req = 1'b0;
                chk("rand_empty_req", 64'(rd_valid), 64'd0);
            end
        end
        while (mq_len.size() > 0) read_pkt(0);
        chk("rand_drained", 64'(pkt_avail), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
